// File: rtl/full_adder_pkg.sv
// Shared definitions for the ripple-carry adder: default width and the 1-bit carry function.
// Latency: not applicable (package only).
// Backpressure: none (package only).
//
// Contents:
//   FA_DEFAULT_WIDTH - default operand width (classic 1-bit full adder)
//   fa_majority()    - carry-out of a single full-adder cell (majority of three inputs)
package full_adder_pkg;

    localparam int FA_DEFAULT_WIDTH = 1;

    // Carry out of one cell is set when at least two of the three inputs are set.
    function automatic logic fa_majority(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/full_adder_if.sv
// Operand/result bundle between the adder and its consumer.
// Latency: Y/X/V combinational, Y_q/X_q/V_q one clk later.
// Backpressure: none; every cycle carries a valid operand set.
//
// Signals:
//   A, B  operands (WIDTH)      C    carry-in
//   Y     sum (WIDTH)           X    carry-out        V    signed overflow
//   Y_q/X_q/V_q  registered copies of Y/X/V
// Modports: master drives operands and reads results; slave is the adder.
interface full_adder_if
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             C;
    logic [WIDTH-1:0] Y;
    logic             X;
    logic             V;
    logic [WIDTH-1:0] Y_q;
    logic             X_q;
    logic             V_q;

    modport master (
        output A, B, C,
        input  Y, X, V, Y_q, X_q, V_q
    );

    modport slave (
        input  A, B, C,
        output Y, X, V, Y_q, X_q, V_q
    );
endinterface

// File: rtl/full_adder_fa_cell.sv
// One-bit full adder cell used as a link in the ripple chain.
// Latency: zero, purely combinational.
// Backpressure: none.
//
// Ports:
//   i_a, i_b  operand bits     i_ci  carry in
//   o_s       sum bit          o_co  carry out
module fa_cell
    import full_adder_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = fa_majority(i_a, i_b, i_ci);

endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder with combinational results plus a registered copy.
// Latency: Y/X/V zero cycles; Y_q/X_q/V_q one clk cycle (cleared by synchronous rst_n).
// Backpressure: none; a new operand set is accepted every cycle.
//
// Ports:
//   clk    rising-edge clock, used only by the output register
//   rst_n  synchronous active-low reset of the registered outputs
//   io     full_adder_if.slave: A/B/C in, Y/X/V and Y_q/X_q/V_q out
module full_adder
    import full_adder_pkg::*;
#(
    parameter int WIDTH = FA_DEFAULT_WIDTH
)(
    input  logic           clk,
    input  logic           rst_n,
    full_adder_if.slave    io
);

    // w_carry[i] is the carry into cell i; w_carry[WIDTH] is the carry out of the MSB.
    logic [WIDTH:0]   w_carry;
    logic [WIDTH-1:0] w_sum;
    logic             w_ovf;

    logic [WIDTH-1:0] r_y_q;
    logic             r_x_q;
    logic             r_v_q;

    assign w_carry[0] = io.C;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        fa_cell u_cell (
            .i_a  (io.A[i]),
            .i_b  (io.B[i]),
            .i_ci (w_carry[i]),
            .o_s  (w_sum[i]),
            .o_co (w_carry[i+1])
        );
    end

    // Signed overflow: carry into the MSB differs from carry out of it.
    // For WIDTH=1 this reduces to carry-out XOR carry-in.
    assign w_ovf = w_carry[WIDTH] ^ w_carry[WIDTH-1];

    assign io.Y = w_sum;
    assign io.X = w_carry[WIDTH];
    assign io.V = w_ovf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y_q <= '0;
            r_x_q <= 1'b0;
            r_v_q <= 1'b0;
        end else begin
            r_y_q <= w_sum;
            r_x_q <= w_carry[WIDTH];
            r_v_q <= w_ovf;
        end
    end

    assign io.Y_q = r_y_q;
    assign io.X_q = r_x_q;
    assign io.V_q = r_v_q;

endmodule

// File: tb/tb_full_adder.sv
// Testbench for full_adder at WIDTH=8 and WIDTH=1, driven in lockstep.
// Stimulus pushes expected results into a scoreboard; a monitor pops and compares each cycle.
// Ends with a single summary line.
module tb_full_adder;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    full_adder_if #(.WIDTH(8)) if8 ();
    full_adder_if #(.WIDTH(1)) if1 ();

    full_adder #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (if8.slave)
    );

    full_adder #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (if1.slave)
    );

    typedef struct {
        logic [7:0] y8;
        logic       x8, v8, y1, x1, v1;
        logic [7:0] q_y8;
        logic       q_x8, q_v8, q_y1, q_x1, q_v1;
    } exp_t;

    typedef struct {
        logic       rn;
        logic [7:0] a8, b8;
        logic       c8, a1, b1, c1;
        logic [7:0] y8;
        logic       x8, v8, y1, x1, v1;
    } vec_t;

    exp_t sb[$];
    exp_t m_e;
    int   n_checks = 0;
    int   n_errors = 0;

    // Model of the previous cycle, used to predict the registered outputs.
    logic       p_rst_n;
    logic [7:0] p_y8;
    logic       p_x8, p_v8, p_y1, p_x1, p_v1;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
        end
    endtask

    // Monitor: results are valid every cycle, so compare at each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                m_e = sb.pop_front();
                chk("y8",   if8.Y,            m_e.y8);
                chk("x8",   {7'b0, if8.X},    {7'b0, m_e.x8});
                chk("v8",   {7'b0, if8.V},    {7'b0, m_e.v8});
                chk("y1",   {7'b0, if1.Y},    {7'b0, m_e.y1});
                chk("x1",   {7'b0, if1.X},    {7'b0, m_e.x1});
                chk("v1",   {7'b0, if1.V},    {7'b0, m_e.v1});
                chk("y8_q", if8.Y_q,          m_e.q_y8);
                chk("x8_q", {7'b0, if8.X_q},  {7'b0, m_e.q_x8});
                chk("v8_q", {7'b0, if8.V_q},  {7'b0, m_e.q_v8});
                chk("y1_q", {7'b0, if1.Y_q},  {7'b0, m_e.q_y1});
                chk("x1_q", {7'b0, if1.X_q},  {7'b0, m_e.q_x1});
                chk("v1_q", {7'b0, if1.V_q},  {7'b0, m_e.q_v1});
            end
        end
    end

    task automatic apply(input vec_t v);
        exp_t e;
        @(posedge clk);
        #2;
        rst_n  = v.rn;
        if8.A  = v.a8;
        if8.B  = v.b8;
        if8.C  = v.c8;
        if1.A  = v.a1;
        if1.B  = v.b1;
        if1.C  = v.c1;
        e.y8   = v.y8;
        e.x8   = v.x8;
        e.v8   = v.v8;
        e.y1   = v.y1;
        e.x1   = v.x1;
        e.v1   = v.v1;
        // The edge just passed captured the previous cycle's result, or zero under reset.
        e.q_y8 = p_rst_n ? p_y8 : 8'h00;
        e.q_x8 = p_rst_n ? p_x8 : 1'b0;
        e.q_v8 = p_rst_n ? p_v8 : 1'b0;
        e.q_y1 = p_rst_n ? p_y1 : 1'b0;
        e.q_x1 = p_rst_n ? p_x1 : 1'b0;
        e.q_v1 = p_rst_n ? p_v1 : 1'b0;
        sb.push_back(e);
        p_rst_n = v.rn;
        p_y8 = v.y8; p_x8 = v.x8; p_v8 = v.v8;
        p_y1 = v.y1; p_x1 = v.x1; p_v1 = v.v1;
    endtask

    // Reference: wide addition; overflow from carry into bit 7 taken off the low 7 bits.
    function automatic vec_t model(input logic rn, input logic [7:0] a8, input logic [7:0] b8,
                                   input logic c8, input logic a1, input logic b1, input logic c1);
        vec_t       v;
        logic [8:0] s8;
        logic [7:0] lo;
        logic [1:0] s1;
        s8 = {1'b0, a8} + {1'b0, b8} + {8'b0, c8};
        lo = {1'b0, a8[6:0]} + {1'b0, b8[6:0]} + {7'b0, c8};
        s1 = {1'b0, a1} + {1'b0, b1} + {1'b0, c1};
        v.rn = rn; v.a8 = a8; v.b8 = b8; v.c8 = c8;
        v.a1 = a1; v.b1 = b1; v.c1 = c1;
        v.y8 = s8[7:0];
        v.x8 = s8[8];
        v.v8 = s8[8] ^ lo[7];
        v.y1 = s1[0];
        v.x1 = s1[1];
        v.v1 = s1[1] ^ c1;
        return v;
    endfunction

    // Hand-computed directed vectors. The 1-bit columns walk the full truth table
    // (V = X ^ C at WIDTH=1); the 8-bit columns cover ripple, overflow, the
    // registered path and synchronous reset hold/release.
    vec_t tbl [9];

    initial begin
        //          rn    a8     b8     c8    a1    b1    c1    y8     x8    v8    y1    x1    v1
        tbl = '{
            '{1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
            '{1'b1, 8'hFF, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0},
            '{1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0},
            '{1'b1, 8'h80, 8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1},
            '{1'b1, 8'h03, 8'h04, 1'b1, 1'b0, 1'b0, 1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1},
            '{1'b0, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0},
            '{1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0},
            '{1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}
        };

        rst_n = 1'b0;
        if8.A = '0; if8.B = '0; if8.C = 1'b0;
        if1.A = '0; if1.B = '0; if1.C = 1'b0;
        p_rst_n = 1'b0;
        p_y8 = 8'h00; p_x8 = 1'b0; p_v8 = 1'b0;
        p_y1 = 1'b0;  p_x1 = 1'b0; p_v1 = 1'b0;

        foreach (tbl[i]) apply(tbl[i]);

        for (int i = 0; i < 1000; i++) begin
            apply(model(($urandom_range(0, 31) != 0),
                        8'($urandom), 8'($urandom), 1'($urandom),
                        1'($urandom), 1'($urandom), 1'($urandom)));
        end

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
